// File: rtl/clock_select_ctrl.sv
// clock_select_ctrl: sequences a clock-mux select change and waits for the
// selected domain's reset to cycle low then high, with a per-wait timeout.
module clock_select_ctrl #(
  parameter int TIMEOUT     = 1023,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_valid_i,
  input  logic req_sel_i,
  output logic req_ready_o,
  output logic select_o,
  output logic select_enable_o,
  input  logic out_rst_n_i,
  output logic cur_sel_o,
  output logic busy_o,
  output logic done_o,
  output logic timeout_err_o
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, FINISH} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [15:0] cnt_q, cnt_d;
  logic sel_q, sel_d, select_q, select_d, se_q, se_d, cur_q, cur_d, err_q, err_d;
  logic rst_s, accept, waiting, hit, expired;
  assign rst_s    = sync_q[SYNC_STAGES-1];
  assign accept   = req_valid_i && req_ready_o;
  assign waiting  = state_q == WAIT_LOW || state_q == WAIT_HIGH;
  assign hit      = state_q == WAIT_LOW ? !rst_s : rst_s;
  assign expired  = cnt_q == 16'(TIMEOUT - 1);
  assign req_ready_o     = state_q == IDLE && !rst_i;
  assign select_o        = select_q;
  assign select_enable_o = se_q;
  assign cur_sel_o       = cur_q;
  assign busy_o          = state_q != IDLE;
  assign done_o          = state_q == FINISH;
  assign timeout_err_o   = err_q;
  always_comb begin
    state_d = state_q;
    sel_d   = accept ? req_sel_i : sel_q;
    err_d   = accept ? 1'b0 : err_q;
    cur_d   = cur_q;
    case (state_q)
      IDLE:      if (accept) state_d = req_sel_i == cur_q ? FINISH : ISSUE;
      ISSUE:     state_d = WAIT_LOW;
      WAIT_LOW,
      WAIT_HIGH: begin
        // the awaited level wins over an expiring counter on the same cycle
        if (hit) state_d = state_q == WAIT_LOW ? WAIT_HIGH : FINISH;
        else if (expired) begin
          state_d = FINISH;
          err_d   = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
        cur_d   = sel_q;
      end
      default:   state_d = IDLE;
    endcase
    se_d     = state_d == ISSUE;
    select_d = se_d ? sel_d : select_q;
    cnt_d    = waiting && state_d == state_q ? cnt_q + 16'd1 : '0;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      sync_q   <= '1;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      select_q <= 1'b0;
      se_q     <= 1'b0;
      cur_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], out_rst_n_i};
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      select_q <= select_d;
      se_q     <= se_d;
      cur_q    <= cur_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_clock_select_ctrl.sv
// tb_clock_select_ctrl: directed vector table, hand sequences and a randomized
// run scored against a waveform-search reference model.
module tb_clock_select_ctrl;
  localparam int TO = 16;
  localparam int MAXC = 512;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_sel = 1'b0, out_rst_n = 1'b1;
  logic req_ready, select, select_enable, cur_sel, busy, done, timeout_err;
  int total = 0, passed = 0, cyc = 0;
  logic o_w [MAXC];
  logic v_w [MAXC];
  logic s_w [MAXC];

  clock_select_ctrl #(.TIMEOUT(TO), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_sel_i(req_sel),
    .req_ready_o(req_ready), .select_o(select), .select_enable_o(select_enable),
    .out_rst_n_i(out_rst_n), .cur_sel_o(cur_sel), .busy_o(busy), .done_o(done),
    .timeout_err_o(timeout_err));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic sel;
    int   lo;
    int   hi;
    int   done_cyc;
    logic se;
    logic cur;
    logic err;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
  endtask

  task automatic reset_outputs_chk(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_select"}, select, 0);
    chk({tag, "_se"}, select_enable, 0);
    chk({tag, "_cur"}, cur_sel, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, timeout_err, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; req_sel = 1'b0; out_rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_outputs_chk("rst");
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic rs(input int n);
    return n < 2 ? 1'b1 : o_w[n-2];
  endfunction

  task automatic run_vec(input vec_t v, input bit rst_first);
    int se_n = 0, dn = 0, dc = -1;
    logic sel_at = 1'bx;
    for (int n = 0; n < MAXC; n++)
      o_w[n] = (v.lo >= 0 && n >= 1 + v.lo && (v.hi < 0 || n < 1 + v.lo + v.hi)) ? 1'b0 : 1'b1;
    if (rst_first) do_reset();
    for (int n = 0; n < 40; n++) begin
      cyc = n;
      req_valid = n == 0; req_sel = v.sel; out_rst_n = o_w[n];
      @(negedge clk);
      chk("vec_busy", busy, n >= 1 && n <= v.done_cyc);
      chk("vec_ready", req_ready, !(n >= 1 && n <= v.done_cyc));
      if (select_enable) begin se_n++; sel_at = select; end
      if (done) begin dn++; dc = n; end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    chk("vec_done_count", dn, 1);
    chk("vec_done_cycle", dc, v.done_cyc);
    chk("vec_se_count", se_n, v.se);
    if (v.se) chk("vec_select_at_se", sel_at, v.sel);
    chk("vec_cur_sel", cur_sel, v.cur);
    chk("vec_timeout_err", timeout_err, v.err);
  endtask

  // Reference model: on each acceptance, search the driven OUT_RST_N waveform
  // (seen through the two-cycle synchronizer) for the falling and rising
  // levels inside each TO-cycle window to predict the finish cycle.
  task automatic run_model(input int ncyc, input bit b2b, output int se_n, output int dn);
    int t = -10, f = -10, acc = 0, lo, hi;
    logic s = 1'b0, chg = 1'b0, ef = 1'b0, cur_e = 1'b0, sel_e = 1'b0, err_e = 1'b0;
    logic vin, sin, idle;
    se_n = 0; dn = 0;
    do_reset();
    for (int n = 0; n < ncyc; n++) begin
      cyc = n;
      if (n == t + 1) begin err_e = 1'b0; if (chg) sel_e = s; end
      if (n == f) err_e = ef;
      if (n == f + 1) cur_e = s;
      vin = b2b ? acc < 2 : v_w[n];
      sin = b2b ? acc == 0 : s_w[n];
      req_valid = vin; req_sel = sin; out_rst_n = o_w[n];
      idle = n > f;
      @(negedge clk);
      chk("m_ready", req_ready, idle);
      chk("m_busy", busy, n > t && n <= f);
      chk("m_done", done, n == f);
      chk("m_se", select_enable, chg && n == t + 1);
      chk("m_select", select, sel_e);
      chk("m_cur_sel", cur_sel, cur_e);
      chk("m_err", timeout_err, err_e);
      if (select_enable) se_n++;
      if (done) dn++;
      if (idle && vin) begin
        acc++; t = n; s = sin; chg = sin != cur_e; ef = 1'b0;
        if (!chg) f = n + 1;
        else begin
          lo = -1;
          for (int m = n + 2; m < n + 2 + TO; m++) if (!rs(m)) begin lo = m; break; end
          if (lo < 0) begin ef = 1'b1; f = n + 2 + TO; end
          else begin
            hi = -1;
            for (int m = lo + 1; m < lo + 1 + TO; m++) if (rs(m)) begin hi = m; break; end
            if (hi < 0) begin ef = 1'b1; f = lo + 1 + TO; end
            else f = hi + 1;
          end
        end
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    int se_n, dn, k, len;
    logic lvl;
    vecs[0] = '{1'b1, 3, 5, 12, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b0, -1, -1, 1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, -1, -1, 18, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 3, -1, 23, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 0, 1, 5, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 14, 1, 19, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 15, 1, 18, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b1);

    // a fresh accepted request clears the sticky timeout flag
    run_vec(vecs[2], 1'b1);
    req_valid = 1'b1; req_sel = 1'b1;
    @(negedge clk);
    chk("clr_err_before", timeout_err, 1);
    chk("clr_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("clr_err_after", timeout_err, 0);
    chk("clr_done", done, 1);
    chk("clr_no_se", select_enable, 0);

    // reset asserted during WAIT_HIGH aborts without DONE
    do_reset();
    for (int n = 0; n < 8; n++) begin
      req_valid = n == 0; req_sel = 1'b1; out_rst_n = n < 4;
      @(posedge clk);
      #1;
    end
    chk("abort_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1 reset_outputs_chk("abort");
    @(negedge clk);
    chk("abort_no_done", done, 0);
    @(posedge clk);
    #1 rst = 1'b0; out_rst_n = 1'b1;
    run_vec(vecs[0], 1'b0);

    // back-to-back requests with REQ_VALID held high
    for (int n = 0; n < MAXC; n++) o_w[n] = (n % 12) >= 6 && (n % 12) < 9 ? 1'b0 : 1'b1;
    run_model(60, 1'b1, se_n, dn);
    chk("b2b_se_count", se_n, 2);
    chk("b2b_done_count", dn, 2);
    chk("b2b_cur_sel", cur_sel, 0);

    // randomized traffic against the reference model
    k = 0;
    while (k < MAXC) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 20);
      for (int j = 0; j < len && k < MAXC; j++) begin o_w[k] = lvl; k++; end
    end
    for (int n = 0; n < MAXC; n++) begin
      v_w[n] = $urandom_range(0, 2) == 0;
      s_w[n] = 1'($urandom_range(0, 1));
    end
    run_model(400, 1'b0, se_n, dn);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
